// File: rtl/multi_approach_signal_ctrl.sv
// multi_approach_signal_ctrl: round-robin N-approach signal controller with ped walk phase and emergency preemption.
// Define DETECT_SKIP_EN to skip approaches with no vehicle present on rotation.
module multi_approach_signal_ctrl #(
  parameter int N_APPR = 4,
  parameter int T_GREEN = 30,
  parameter int T_YELLOW = 5,
  parameter int T_ALLRED = 2,
  parameter int T_WALK = 10,
  parameter int EMERG_MAX = 600,
  parameter int TW = 16,
  localparam int IW = (N_APPR > 2) ? $clog2(N_APPR) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [N_APPR-1:0]   ped_req,
  input  logic [N_APPR-1:0]   veh_present,
  input  logic                emerg_req,
  input  logic [IW-1:0]       emerg_dir,
  output logic [3*N_APPR-1:0] light,
  output logic [N_APPR-1:0]   walk,
  output logic [N_APPR-1:0]   buzzer,
  output logic [IW-1:0]       active_idx,
  output logic                emerg_active
);
  typedef enum logic [2:0] {ALLRED, GREEN, YELLOW, WALK, E_GREEN, E_YELLOW} state_t;
  state_t state;
  logic [IW-1:0] idx, nxt, adv;
  logic [TW-1:0] timer, dur_m1;
  logic [N_APPR-1:0] ped_lat;
  logic armed, fresh, emerg_ok, done;

  function automatic logic [IW-1:0] step(input logic [IW-1:0] i, input int k);
    return IW'((int'(i) + k) % N_APPR);
  endfunction

`ifdef DETECT_SKIP_EN
  always_comb begin
    adv = idx;
    for (int k = N_APPR - 1; k >= 1; k--)
      if (veh_present[step(idx, k)]) adv = step(idx, k);
  end
`else
  logic unused_veh;
  assign unused_veh = ^veh_present;
  assign adv = step(idx, 1);
`endif

  // fresh: first green after reset is idx itself rather than its successor
  assign nxt = fresh ? idx : adv;
  assign emerg_ok = emerg_req && armed && int'(emerg_dir) < N_APPR;
  assign dur_m1 = state == GREEN ? TW'(T_GREEN - 1) :
                  (state == YELLOW || state == E_YELLOW) ? TW'(T_YELLOW - 1) :
                  state == WALK ? TW'(T_WALK - 1) :
                  state == E_GREEN ? TW'(EMERG_MAX - 1) : TW'(T_ALLRED - 1);
  assign done = timer == dur_m1;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ALLRED;
      idx <= '0;
      timer <= '0;
      ped_lat <= '0;
      walk <= '0;
      armed <= 1'b1;
      fresh <= 1'b1;
    end else begin
      ped_lat <= ped_lat | ped_req;
      armed <= armed | ~emerg_req;
      if (tick) begin
        timer <= timer + 1'b1;
        case (state)
          ALLRED: if (done) begin
            timer <= '0;
            if (emerg_ok) begin
              state <= E_GREEN;
              idx <= emerg_dir;
              fresh <= 1'b0;
            end else if (|ped_lat) begin
              state <= WALK;
              walk <= ped_lat;
              ped_lat <= ped_req;
            end else begin
              state <= GREEN;
              idx <= nxt;
              fresh <= 1'b0;
            end
          end
          GREEN: if (emerg_ok || done) begin
            timer <= '0;
            state <= (emerg_ok && idx == emerg_dir) ? E_GREEN : YELLOW;
          end
          YELLOW, E_YELLOW: if (done) begin
            timer <= '0;
            state <= ALLRED;
          end
          WALK: if (emerg_ok || done) begin
            timer <= '0;
            walk <= '0;
            state <= emerg_ok ? ALLRED : GREEN;
            if (!emerg_ok) begin
              idx <= nxt;
              fresh <= 1'b0;
            end
          end
          E_GREEN: if (!emerg_req || done) begin
            timer <= '0;
            state <= E_YELLOW;
            if (emerg_req) armed <= 1'b0;
          end
          default: state <= ALLRED;
        endcase
      end
    end

  always_comb begin
    for (int i = 0; i < N_APPR; i++) begin
      light[3*i +: 3] = (IW'(i) != idx) ? 3'b100 :
                        (state == GREEN || state == E_GREEN) ? 3'b001 :
                        (state == YELLOW || state == E_YELLOW) ? 3'b010 : 3'b100;
      buzzer[i] = IW'(i) == nxt && (state == YELLOW || (state == ALLRED && !fresh && !(|ped_lat)));
    end
  end

  assign active_idx = (state == ALLRED || state == WALK) ? nxt : idx;
  assign emerg_active = state == E_GREEN;
endmodule

// File: tb/tb_multi_approach_signal_ctrl.sv
// tb_multi_approach_signal_ctrl: directed checks of rotation, walk, preemption, timeout, reset and tick gating.
module tb_multi_approach_signal_ctrl;
  localparam int N = 4;
  logic clk = 0, reset = 0, tick = 1, emerg_req = 0;
  logic [N-1:0] ped_req = '0, veh_present = '1, walk, buzzer;
  logic [1:0] emerg_dir = '0, active_idx;
  logic [3*N-1:0] light;
  logic emerg_active;
  int total = 0, bad = 0;

  multi_approach_signal_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .ped_req(ped_req), .veh_present(veh_present),
    .emerg_req(emerg_req), .emerg_dir(emerg_dir), .light(light), .walk(walk),
    .buzzer(buzzer), .active_idx(active_idx), .emerg_active(emerg_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3*N-1:0] lamp(input int g, input logic [2:0] v);
    lamp = {N{3'b100}};
    if (g >= 0) lamp[3*g +: 3] = v;
  endfunction

  initial begin
    #1 reset = 1;
    #1;
    check("rst_light", light, lamp(-1, 0));
    check("rst_walk", walk, 0);
    check("rst_buzz", buzzer, 0);
    check("rst_emerg", emerg_active, 0);
    check("rst_aidx", active_idx, 0);
    @(negedge clk) reset = 0;
    // normal rotation
    cyc(1);
    check("ar_start", light, lamp(-1, 0));
    check("ar_start_buzz", buzzer, 0);
    cyc(1);
    check("g0", light, lamp(0, 3'b001));
    cyc(29);
    check("g0_last", light, lamp(0, 3'b001));
    cyc(1);
    check("y0", light, lamp(0, 3'b010));
    check("y0_buzz", buzzer, 4'b0010);
    cyc(5);
    check("ar0", light, lamp(-1, 0));
    check("ar0_buzz", buzzer, 4'b0010);
    check("ar0_aidx", active_idx, 1);
    cyc(2);
    check("g1", light, lamp(1, 3'b001));
    for (int g = 2; g <= 4; g++) begin
      cyc(37);
      check("rot", light, lamp(g % 4, 3'b001));
      check("rot_aidx", active_idx, g % 4);
    end
    // pedestrian walk requested during GREEN(0)
    ped_req = 4'b0100;
    cyc(1);
    ped_req = '0;
    cyc(34);
    check("ped_ar", light, lamp(-1, 0));
    check("ped_ar_buzz", buzzer, 0);
    cyc(2);
    check("walk_on", walk, 4'b0100);
    check("walk_light", light, lamp(-1, 0));
    check("walk_aidx", active_idx, 1);
    cyc(9);
    check("walk_last", walk, 4'b0100);
    cyc(1);
    check("walk_off", walk, 0);
    check("walk_g1", light, lamp(1, 3'b001));
    // emergency to approach 3 from GREEN(1)
    emerg_req = 1;
    emerg_dir = 3;
    cyc(1);
    check("em_y1", light, lamp(1, 3'b010));
    cyc(5);
    check("em_ar", light, lamp(-1, 0));
    cyc(2);
    check("eg3", light, lamp(3, 3'b001));
    check("eg3_act", emerg_active, 1);
    check("eg3_aidx", active_idx, 3);
    cyc(10);
    emerg_req = 0;
    cyc(1);
    check("ey3", light, lamp(3, 3'b010));
    check("ey3_act", emerg_active, 0);
    cyc(5);
    check("ey_ar_aidx", active_idx, 0);
    cyc(2);
    check("em_resume_g0", light, lamp(0, 3'b001));
    // emergency timeout, direct from GREEN(0)
    emerg_req = 1;
    emerg_dir = 0;
    cyc(1);
    check("eg0", light, lamp(0, 3'b001));
    check("eg0_act", emerg_active, 1);
    cyc(599);
    check("eg0_last", emerg_active, 1);
    cyc(1);
    check("to_ey0", light, lamp(0, 3'b010));
    check("to_act", emerg_active, 0);
    cyc(7);
    check("disarm_g1", light, lamp(1, 3'b001));
    check("disarm_act", emerg_active, 0);
    emerg_dir = 1;
    cyc(5);
    check("disarm_hold", emerg_active, 0);
    emerg_req = 0;
    cyc(1);
    emerg_req = 1;
    cyc(1);
    check("rearm_eg1", emerg_active, 1);
    check("rearm_light", light, lamp(1, 3'b001));
    // async reset mid-E_GREEN
    cyc(3);
    reset = 1;
    #1;
    check("ar_rst_light", light, lamp(-1, 0));
    check("ar_rst_act", emerg_active, 0);
    check("ar_rst_buzz", buzzer, 0);
    check("ar_rst_walk", walk, 0);
    emerg_req = 0;
    @(negedge clk) reset = 0;
    cyc(2);
    check("rst_g0", light, lamp(0, 3'b001));
    // tick low freezes
    tick = 0;
    cyc(100);
    check("freeze", light, lamp(0, 3'b001));
    tick = 1;
    cyc(29);
    check("thaw_g0", light, lamp(0, 3'b001));
    cyc(1);
    check("thaw_y0", light, lamp(0, 3'b010));
    // vehicle detector skip
    veh_present = 4'b0101;
`ifdef DETECT_SKIP_EN
    cyc(7);
    check("skip_a", light, lamp(2, 3'b001));
    cyc(37);
    check("skip_b", light, lamp(0, 3'b001));
`else
    cyc(7);
    check("noskip_a", light, lamp(1, 3'b001));
    cyc(37);
    check("noskip_b", light, lamp(2, 3'b001));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
